// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_pkg;

  // One register-file write request.
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         DEFAULT_DEPTH = 4;

  // A query matches only if it names a real register ($0 is never tracked).
  function automatic logic addr_hit(input logic [4:0] q, input logic [4:0] a);
    return (q != REG_ZERO) && (q == a);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of write requests for multiply/divide results.
// Pointers wrap modulo DEPTH (power of two); occupancy is kept explicitly.
// Every entry's a3 and valid bit are exported for the decode busy compare.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      push,
  input  wb_req_t                   push_data,
  input  logic                      pop,
  output wb_req_t                   head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][4:0]     ent_a3
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t        mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // Guard against overflow/underflow locally, so pointers never collide.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers, per-entry valid bits and occupancy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ent_valid <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr]       <= push_data;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flatten entry destinations for the busy compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_a3[i] = mem[i].a3;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter owning the single register-file write port.
// Priority: pipeline W-stage write, then FIFO head, else idle.
// Optional macro RF_WB_MD_BYPASS_EN lets an MD result arriving at an empty,
// otherwise idle arbiter skip the FIFO and load the output register directly.
//
// MD handshake: a result transfers on a rising edge where MD_Valid and
// MD_Ready are both 1; MD_Ready depends only on registered occupancy, never
// on MD_Valid or on a same-cycle pop.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   W_Wr,
  input  logic [4:0]             W_A3,
  input  logic [31:0]            W_WD,
  input  logic [31:0]            W_PC,
  input  logic                   MD_Valid,
  output logic                   MD_Ready,
  input  logic [4:0]             MD_A3,
  input  logic [31:0]            MD_WD,
  input  logic [31:0]            MD_PC,
  input  logic [4:0]             Q_A1,
  input  logic [4:0]             Q_A2,
  input  logic [4:0]             Q_A3,
  output logic                   Q_Busy,
  output logic                   RF_Wr,
  output logic [4:0]             RF_A3,
  output logic [31:0]            RF_WD,
  output logic [31:0]            RF_PC,
  output logic [$clog2(DEPTH):0] MD_Count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t              head;
  wb_req_t              md_req;
  wb_req_t              rf_q;
  logic [DEPTH-1:0]     ent_valid;
  logic [DEPTH-1:0][4:0] ent_a3;
  logic                 pipe_wr;
  logic                 md_hs;
  logic                 md_keep;
  logic                 bypass;
  logic                 do_pop;
  logic                 do_push;

  assign md_req   = '{a3: MD_A3, wd: MD_WD, pc: MD_PC};
  assign MD_Ready = Reset && (MD_Count < CW'(DEPTH));
  assign md_hs    = MD_Valid && MD_Ready;
  // Results for $0 are accepted but dropped.
  assign md_keep  = md_hs && (MD_A3 != REG_ZERO);
  // A write to $0 from the pipeline is no write; the FIFO may drain then.
  assign pipe_wr  = W_Wr && (W_A3 != REG_ZERO);
  assign do_pop   = !pipe_wr && (MD_Count != '0);

`ifdef RF_WB_MD_BYPASS_EN
  assign bypass = md_keep && !pipe_wr && (MD_Count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign do_push = md_keep && !bypass;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (do_push),
    .push_data (md_req),
    .pop       (do_pop),
    .head      (head),
    .count     (MD_Count),
    .ent_valid (ent_valid),
    .ent_a3    (ent_a3)
  );

  // Output register: load one source per cycle; payload holds when idle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RF_Wr <= 1'b0;
      rf_q  <= '0;
    end else if (pipe_wr) begin
      RF_Wr <= 1'b1;
      rf_q  <= '{a3: W_A3, wd: W_WD, pc: W_PC};
    end else if (do_pop) begin
      RF_Wr <= 1'b1;
      rf_q  <= head;
    end else if (bypass) begin
      RF_Wr <= 1'b1;
      rf_q  <= md_req;
    end else begin
      RF_Wr <= 1'b0;
    end
  end

  assign RF_A3 = rf_q.a3;
  assign RF_WD = rf_q.wd;
  assign RF_PC = rf_q.pc;

  // Busy if any nonzero query names a buffered or not-yet-committed write.
  always_comb begin
    Q_Busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (addr_hit(Q_A1, ent_a3[i]) || addr_hit(Q_A2, ent_a3[i]) ||
                           addr_hit(Q_A3, ent_a3[i])))
        Q_Busy = 1'b1;
    end
    if (RF_Wr && (addr_hit(Q_A1, RF_A3) || addr_hit(Q_A2, RF_A3) || addr_hit(Q_A3, RF_A3)))
      Q_Busy = 1'b1;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps plus a random phase,
// checked against a queue-based model of the write-back rules.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef RF_WB_MD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk, Reset;
  logic        W_Wr;
  logic [4:0]  W_A3;
  logic [31:0] W_WD, W_PC;
  logic        MD_Valid, MD_Ready;
  logic [4:0]  MD_A3;
  logic [31:0] MD_WD, MD_PC;
  logic [4:0]  Q_A1, Q_A2, Q_A3;
  logic        Q_Busy, RF_Wr;
  logic [4:0]  RF_A3;
  logic [31:0] RF_WD, RF_PC;
  logic [$clog2(DEPTH):0] MD_Count;

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .W_Wr(W_Wr), .W_A3(W_A3), .W_WD(W_WD), .W_PC(W_PC),
    .MD_Valid(MD_Valid), .MD_Ready(MD_Ready),
    .MD_A3(MD_A3), .MD_WD(MD_WD), .MD_PC(MD_PC),
    .Q_A1(Q_A1), .Q_A2(Q_A2), .Q_A3(Q_A3), .Q_Busy(Q_Busy),
    .RF_Wr(RF_Wr), .RF_A3(RF_A3), .RF_WD(RF_WD), .RF_PC(RF_PC),
    .MD_Count(MD_Count)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: pending MD results in arrival order, plus output register.
  logic [68:0] exp_q [$];
  logic        m_wr;
  wb_req_t     m_rf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_model();
    logic [4:0] qs [3];
    qs[0] = Q_A1; qs[1] = Q_A2; qs[2] = Q_A3;
    for (int k = 0; k < 3; k++) begin
      if (qs[k] != 5'd0) begin
        foreach (exp_q[i]) if (exp_q[i][68:64] == qs[k]) return 1'b1;
        if (m_wr && m_rf.a3 == qs[k]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    W_Wr = 0; W_A3 = 0; W_WD = 0; W_PC = 0;
    MD_Valid = 0; MD_A3 = 0; MD_WD = 0; MD_PC = 0;
    Q_A1 = 0; Q_A2 = 0; Q_A3 = 0;
  endtask

  task automatic drive_w(input logic wr, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc);
    W_Wr = wr; W_A3 = a3; W_WD = wd; W_PC = pc;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                          input logic [31:0] pc);
    MD_Valid = v; MD_A3 = a3; MD_WD = wd; MD_PC = pc;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cycle();
    logic    hs, pipe, byp, nwr;
    wb_req_t nrf;
    #1;
    chk("md_ready", MD_Ready, exp_q.size() < DEPTH);
    chk("q_busy", Q_Busy, busy_model());
    hs   = MD_Valid && (exp_q.size() < DEPTH);
    pipe = W_Wr && (W_A3 != 5'd0);
    byp  = 1'b0;
    nwr  = 1'b1;
    if (pipe) nrf = '{a3: W_A3, wd: W_WD, pc: W_PC};
    else if (exp_q.size() > 0) nrf = exp_q.pop_front();
    else if (BYP && hs && MD_A3 != 5'd0) begin
      nrf = '{a3: MD_A3, wd: MD_WD, pc: MD_PC};
      byp = 1'b1;
    end else begin
      nwr = 1'b0;
      nrf = m_rf;
    end
    if (hs && MD_A3 != 5'd0 && !byp) exp_q.push_back({MD_A3, MD_WD, MD_PC});
    @(posedge Clk);
    #1;
    m_wr = nwr;
    m_rf = nrf;
    chk("rf_wr", RF_Wr, m_wr);
    chk("rf_a3", RF_A3, m_rf.a3);
    chk("rf_wd", RF_WD, m_rf.wd);
    chk("rf_pc", RF_PC, m_rf.pc);
    chk("md_count", MD_Count, exp_q.size());
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 3 * DEPTH && (exp_q.size() > 0 || m_wr); i++) cycle();
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    idle_inputs();
    m_wr = 0;
    m_rf = '0;
    Reset = 0;

    // Reset held 3 cycles with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      drive_w(1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom);
      drive_md(1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom);
      Q_A1 = W_A3; Q_A2 = MD_A3; Q_A3 = 5'd1;
      @(posedge Clk);
      #1;
      chk("rst_rf_wr", RF_Wr, 0);
      chk("rst_rf_a3", RF_A3, 0);
      chk("rst_rf_wd", RF_WD, 0);
      chk("rst_rf_pc", RF_PC, 0);
      chk("rst_count", MD_Count, 0);
      chk("rst_ready", MD_Ready, 0);
      chk("rst_busy", Q_Busy, 0);
    end
    idle_inputs();
    Reset = 1;
    #1;
    chk("post_rst_ready", MD_Ready, 1);

    // Pipeline write, then pipeline write to $0.
    drive_w(1'b1, 5'd5, 32'h1234, 32'h3000);
    cycle();
    chk("pipe_a3", RF_A3, 5);
    chk("pipe_wd", RF_WD, 32'h1234);
    chk("pipe_pc", RF_PC, 32'h3000);
    drive_w(1'b1, 5'd0, 32'h5555, 32'h3004);
    cycle();
    chk("pipe_zero_wr", RF_Wr, 0);

    // Priority: MD results queue behind continuous pipeline writes.
    drive_w(1'b1, 5'd20, 32'h20, 32'h4000);
    drive_md(1'b1, 5'd8, 32'h8888, 32'h5000);
    cycle();
    drive_w(1'b1, 5'd21, 32'h21, 32'h4004);
    drive_md(1'b1, 5'd9, 32'h9999, 32'h5004);
    cycle();
    drive_md(1'b0, 5'd0, 0, 0);
    drive_w(1'b1, 5'd22, 32'h22, 32'h4008);
    Q_A1 = 5'd8;
    cycle();
    chk("prio_pipe_a3", RF_A3, 22);
    chk("prio_busy8", Q_Busy, 1);
    drive_w(1'b0, 5'd0, 0, 0);
    cycle();
    chk("prio_first8", RF_A3, 8);
    Q_A1 = 5'd9;
    cycle();
    chk("prio_second9", RF_A3, 9);
    chk("prio_busy9_uncommitted", Q_Busy, 1);
    cycle();
    chk("prio_busy9_fall", Q_Busy, 0);

    // Full and wrap: fill under pipeline pressure, then interleave drain.
    drive_w(1'b1, 5'd1, 32'h1, 32'h6000);
    for (int k = 0; k <= DEPTH; k++) begin
      drive_md(1'b1, 5'((k % 7) + 2), 32'h100 + k, 32'h7000 + 4 * k);
      cycle();
    end
    chk("full_count", MD_Count, DEPTH);
    chk("full_ready", MD_Ready, 0);
    for (int k = DEPTH + 1; k < DEPTH + 8; k++) begin
      drive_w(1'(k & 1), 5'd1, 32'h200 + k, 32'h6100 + 4 * k);
      drive_md(1'b1, 5'((k % 7) + 2), 32'h100 + k, 32'h7000 + 4 * k);
      cycle();
    end
    drain();

    // Simultaneous push and pop at count 2.
    drive_w(1'b1, 5'd1, 32'h11, 32'h8000);
    drive_md(1'b1, 5'd3, 32'hA0, 32'h9000);
    cycle();
    drive_md(1'b1, 5'd4, 32'hA1, 32'h9004);
    cycle();
    drive_w(1'b0, 5'd0, 0, 0);
    drive_md(1'b1, 5'd5, 32'hA2, 32'h9008);
    cycle();
    chk("pp_count", MD_Count, 2);
    chk("pp_oldest", RF_WD, 32'hA0);
    drain();

    // MD latency into an empty, idle arbiter.
    drive_md(1'b1, 5'd10, 32'hBEEF, 32'hA000);
    cycle();
    drive_md(1'b0, 5'd0, 0, 0);
    chk("lat_n1", RF_Wr, BYP);
    cycle();
    chk("lat_n2", RF_Wr, !BYP);
    chk("lat_wd", RF_WD, 32'hBEEF);
    drain();

    // Discarded MD result for $0.
    drive_md(1'b1, 5'd0, 32'hDEAD, 32'hB000);
    cycle();
    chk("md_zero_count", MD_Count, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive_w(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      drive_md(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom);
      Q_A1 = 5'($urandom_range(0, 7));
      Q_A2 = 5'($urandom_range(0, 7));
      Q_A3 = 5'($urandom_range(0, 7));
      cycle();
    end
    drain();

    // Asynchronous reset while a write is pending.
    drive_w(1'b1, 5'd6, 32'h66, 32'hC000);
    drive_md(1'b1, 5'd7, 32'h77, 32'hC004);
    cycle();
    #2;
    Reset = 0;
    #1;
    chk("arst_rf_wr", RF_Wr, 0);
    chk("arst_count", MD_Count, 0);
    chk("arst_ready", MD_Ready, 0);
    exp_q.delete();
    m_wr = 0;
    m_rf = '0;
    idle_inputs();
    @(posedge Clk);
    #1;
    Reset = 1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that owns the single register-file write port. It merges the in-order pipeline W-stage write with results from the long-latency multiply/divide unit, which are buffered in a small FIFO. It drives registered write requests (address, data, PC) into the register file. It also reports to decode when a register still has an uncommitted buffered write, so decode can stall.

## Interface
Parameters:
- DEPTH, 4, MD result FIFO entries; power of two, minimum 2.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- W_Wr  in  1  pipeline write request this cycle.
- W_A3  in  5  pipeline destination register.
- W_WD  in  32  pipeline write data.
- W_PC  in  32  PC of the writing instruction.
- MD_Valid  in  1  MD unit offers a result.
- MD_Ready  out  1  arbiter accepts the MD result this cycle.
- MD_A3  in  5  MD destination register.
- MD_WD  in  32  MD result data.
- MD_PC  in  32  PC of the MD instruction.
- Q_A1, Q_A2, Q_A3  in  5 each  decode source/destination query addresses.
- Q_Busy  out  1  some query address (nonzero) matches a pending write.
- RF_Wr  out  1  registered write enable to register file.
- RF_A3  out  5  registered write address.
- RF_WD  out  32  registered write data.
- RF_PC  out  32  registered PC, for the write trace.
- MD_Count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset low: FIFO empty, RF_Wr=0, RF_A3=0, RF_WD=0, RF_PC=0, MD_Count=0, MD_Ready=0, Q_Busy=0.
- MD_Ready = Reset && (MD_Count < DEPTH). It is based on the registered count only, with no same-cycle pop look-ahead.
- MD push on MD_Valid && MD_Ready. If MD_A3==0, the result is accepted and discarded without being stored.
- Each cycle the output register loads exactly one source, in this priority order:
  - Pipeline: W_Wr && W_A3!=0.
  - FIFO head (pop): FIFO non-empty and no pipeline write.
  - Idle: RF_Wr=0. RF_A3, RF_WD and RF_PC hold their previous values.
- A pipeline write with W_A3==0 counts as no write. The FIFO may drain in that cycle.
- Push and pop in the same cycle are legal. The count is unchanged, and the pushed entry goes behind the head.
- A push into an empty FIFO cannot pop in the same cycle (no bypass, unless the macro below is defined).
- Q_Busy is combinational. It is 1 if any nonzero Q_Ax equals:
  - the A3 of any valid FIFO entry, or
  - RF_A3 while RF_Wr=1 (not yet committed).
- The pipeline write port is never tracked by Q_Busy, because the W stage forwards its own value.
- The block does no reordering. WAW/RAW safety relies on decode stalling on Q_Busy.
- The FIFO uses read/write pointers that wrap modulo DEPTH, plus an explicit count. Full means count==DEPTH.

## Timing
- Pipeline write sampled at edge n: RF_Wr=1 during cycle n+1. The register file commits at edge n+1.
- MD result accepted at edge n into an empty FIFO, with no pipeline writes: popped at edge n+1, RF_Wr=1 during cycle n+2.
- Under continuous pipeline writes, the FIFO starves indefinitely. This is accepted behaviour, because the pipeline stalls on Q_Busy.
- Reset asserted mid-operation: pending FIFO entries are lost and RF_Wr drops immediately (asynchronous).

## Configuration
- RF_WB_MD_BYPASS_EN defined:
  - When the FIFO is empty, no pipeline write is present and the MD handshake occurs, the MD result loads the output register directly. Latency drops to RF_Wr during cycle n+1, and the count is unchanged.
- RF_WB_MD_BYPASS_EN undefined:
  - Every MD result passes through the FIFO, with a minimum 2-cycle latency.

## Structure
- Package rf_wb_pkg holds:
  - typedef wb_req_t {a3[4:0], wd[31:0], pc[31:0]};
  - constant REG_ZERO = 5'd0;
  - default DEPTH.
- Sub-module rf_wb_fifo: synchronous FIFO of wb_req_t with push/pop/count. It exposes all entries' a3 and valid bits for the Q_Busy compare.
- The top level holds the priority mux, the output register and the Q_Busy logic.

## Test plan
- Reset: hold Reset low 3 cycles while toggling all inputs -> all outputs 0, MD_Ready=0. After release, MD_Ready=1.
- Pipeline only: W_Wr=1, W_A3=5, W_WD=0x1234, W_PC=0x3000 at edge n -> cycle n+1 shows RF_Wr=1, RF_A3=5, RF_WD=0x1234, RF_PC=0x3000. Repeat with W_A3=0 -> RF_Wr=0.
- Priority: fill the FIFO with MD writes to $8,$9 while the pipeline writes every cycle -> only pipeline writes appear, and Q_Busy=1 for Q_A1=8. When the pipeline idles 2 cycles -> $8 then $9 appear in order, and Q_Busy falls after the $9 commit cycle.
- Full/wrap: push DEPTH+3 results with drain interleaved -> MD_Ready=0 exactly when count==DEPTH, no entry lost or duplicated, order preserved across pointer wrap.
- Simultaneous push/pop at count=2 -> count stays 2, and the popped entry is the oldest.
- Bypass (macro on): empty FIFO, MD write $10=0xBEEF at edge n -> RF_Wr=1 in cycle n+1. With the macro off -> cycle n+2.
